fetch_queue: RTL

Parametrised instruction-fetch stage with a decoupling buffer. It issues sequential fetches to a one-cycle-latency instruction memory and places {inst, pc} pairs into a DEPTH-entry FIFO that the decode stage drains through a valid/ready handshake. Three inputs control the fetch stream: redirect (jump target, flushes all queued and in-flight work), hold (unresolved branch in decode, pauses new fetches) and consumer backpressure. It replaces the stall-driven PC mux and inline ROM read as the front end of the pipeline.

---
 rtl/fetch_queue.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generator driving a one-cycle-latency
// instruction memory, with a DEPTH-entry decoupling FIFO toward decode.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            hold,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of two and at least 4");
    end

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           mem_q [DEPTH];

    logic credit_ok;
    logic push;
    logic pop;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^redirect_addr[1:0];

    // Credit counts the outstanding response so a full FIFO can never be overrun.
    assign credit_ok = (SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(DEPTH);
    assign imem_req  = !rst && !redirect_en && !hold && credit_ok;
    assign imem_addr = fetch_pc_q;

    assign id_valid = (count_q != '0);
    assign id_inst  = mem_q[rd_ptr_q].inst;
    assign id_pc    = mem_q[rd_ptr_q].pc;

    assign push = inflight_q && !redirect_en;
    assign pop  = id_valid && id_ready && !redirect_en;

    // Next-state for PC, in-flight tracking and FIFO bookkeeping; redirect wins.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (redirect_en) begin
            fetch_pc_d = {redirect_addr[XLEN-1:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (imem_req) begin
                fetch_pc_d    = fetch_pc_q + XLEN'(4);
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Entry storage is cleared on reset so the head reads zero before the first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= '{inst: imem_rdata, pc: inflight_pc_q};
        end
    end

endmodule
